// File: rtl/conv_datapath_pipelined.sv
// Pipelined KxK convolution MAC: S1 multiply, S2 adder tree, S3 channel
// accumulate + bias + round/saturate. Ports: weight load (weight_write,
// weight_ch, weights), beat in (in_valid/in_ready, pixel_data, bias),
// result out (out_valid/out_ready, add_result, result_sat).
// Optional: define CONV_DATAPATH_RELU_EN to clamp negative results to 0.
module conv_datapath_pipelined #(
  parameter int DATA_WIDTH   = 16,
  parameter int KERNEL_SIZE  = 5,
  parameter int FRAC_BIT     = 8,
  parameter int NUM_CHANNELS = 1,
  parameter int ACC_WIDTH    = 2*DATA_WIDTH+8
) (
  input  logic clk,
  input  logic reset,
  input  logic weight_write,
  input  logic [((NUM_CHANNELS > 1) ?
    $clog2(NUM_CHANNELS) : 1)-1:0] weight_ch,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights,
  input  logic [DATA_WIDTH-1:0] bias,
  input  logic in_valid,
  output logic in_ready,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] pixel_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [DATA_WIDTH-1:0] add_result,
  output logic result_sat
);

  localparam int KK  = KERNEL_SIZE*KERNEL_SIZE;
  localparam int VW  = KK*DATA_WIDTH;
  localparam int PW  = 2*DATA_WIDTH;
  localparam int CHW = (NUM_CHANNELS > 1) ?
    $clog2(NUM_CHANNELS) : 1;
  localparam int NB  = 1 << CHW;

  localparam logic signed [ACC_WIDTH-1:0] RND =
    {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (FRAC_BIT-1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}},
     {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}},
     {(DATA_WIDTH-1){1'b0}}};

  // Bank array padded to a power of two so the
  // counter indexes it at full width; pad banks stay 0.
  logic [VW-1:0] r_wbank [NB];
  logic [CHW-1:0] r_ch;

  logic w_stall;
  logic w_accept;
  logic w_first;
  logic w_last;
  logic [VW-1:0] w_wsel;

  logic signed [PW-1:0] w_prod [KK];
  logic signed [PW-1:0] r_s1_prod [KK];
  logic r_s1_valid;
  logic r_s1_last;
  logic r_s1_first;
  logic signed [DATA_WIDTH-1:0] r_s1_bias;

  logic signed [ACC_WIDTH-1:0] w_sum;
  logic signed [ACC_WIDTH-1:0] r_s2_sum;
  logic r_s2_valid;
  logic r_s2_last;
  logic r_s2_first;
  logic signed [DATA_WIDTH-1:0] r_s2_bias;

  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH-1:0] w_acc_base;
  logic signed [ACC_WIDTH-1:0] w_acc_new;
  logic signed [ACC_WIDTH-1:0] w_bias_ext;
  logic signed [ACC_WIDTH-1:0] w_biased;
  logic signed [ACC_WIDTH-1:0] w_rounded;
  logic [DATA_WIDTH-1:0] w_clip;
  logic [DATA_WIDTH-1:0] w_res;
  logic w_sat;

  logic r_out_valid;
  logic [DATA_WIDTH-1:0] r_out;
  logic r_sat;

  // Whole pipeline freezes while a result waits.
  assign w_stall  = r_out_valid & ~out_ready;
  assign in_ready = ~w_stall;
  assign w_accept = in_valid & ~w_stall;

  assign w_first = (r_ch == '0);
  assign w_last  = (int'(r_ch) == NUM_CHANNELS-1);
  assign w_wsel  = r_wbank[r_ch];

  for (genvar i = 0; i < KK; i++) begin : g_mul
    logic signed [DATA_WIDTH-1:0] w_px;
    logic signed [DATA_WIDTH-1:0] w_wt;
    assign w_px = pixel_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign w_wt = w_wsel[i*DATA_WIDTH +: DATA_WIDTH];
    assign w_prod[i] = PW'(w_px) * PW'(w_wt);
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < KK; i++)
      w_sum = w_sum + ACC_WIDTH'(r_s1_prod[i]);
  end

  // Rounding happens once, after all channels and bias.
  always_comb begin
    w_acc_base = r_s2_first ? '0 : r_acc;
    w_acc_new  = w_acc_base + r_s2_sum;
    w_bias_ext = ACC_WIDTH'(r_s2_bias);
    w_biased   = w_acc_new + (w_bias_ext <<< FRAC_BIT);
    w_rounded  = (w_biased + RND) >>> FRAC_BIT;
  end

  always_comb begin
    w_sat  = 1'b0;
    w_clip = w_rounded[DATA_WIDTH-1:0];
    if (w_rounded > SAT_MAX) begin
      w_sat  = 1'b1;
      w_clip = SAT_MAX[DATA_WIDTH-1:0];
    end else if (w_rounded < SAT_MIN) begin
      w_sat  = 1'b1;
      w_clip = SAT_MIN[DATA_WIDTH-1:0];
    end
  end

`ifdef CONV_DATAPATH_RELU_EN
  assign w_res = w_clip[DATA_WIDTH-1] ? '0 : w_clip;
`else
  assign w_res = w_clip;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NB; b++)
        r_wbank[b] <= '0;
      r_ch <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_bias  <= '0;
      for (int i = 0; i < KK; i++)
        r_s1_prod[i] <= '0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_bias  <= '0;
      r_s2_sum   <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_sat       <= 1'b0;
    end else begin
      if (weight_write &&
          int'(weight_ch) < NUM_CHANNELS)
        r_wbank[weight_ch] <= weights;
      if (!w_stall) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          for (int i = 0; i < KK; i++)
            r_s1_prod[i] <= w_prod[i];
          r_s1_last  <= w_last;
          r_s1_first <= w_first;
          r_s1_bias  <= bias;
          r_ch <= w_last ? '0 : r_ch + CHW'(1);
        end
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_sum   <= w_sum;
          r_s2_last  <= r_s1_last;
          r_s2_first <= r_s1_first;
          r_s2_bias  <= r_s1_bias;
        end
        r_out_valid <= 1'b0;
        if (r_s2_valid) begin
          if (r_s2_last) begin
            r_out       <= w_res;
            r_sat       <= w_sat;
            r_out_valid <= 1'b1;
          end else begin
            r_acc <= w_acc_new;
          end
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign add_result = r_out;
  assign result_sat = r_sat;

endmodule

// File: tb/tb_conv_datapath_pipelined.sv
// Scoreboard bench for conv_datapath_pipelined: one NC=1 and one
// NC=2 instance, directed vectors, queued expectations, negedge monitors.
module tb_conv_datapath_pipelined;

  localparam int DW = 16;
  localparam int KK = 25;
  localparam int VW = KK*DW;

  typedef struct {
    logic [15:0] res;
    logic sat;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic ww1, iv1, ir1, ov1, ordy1, sat1;
  logic [0:0] wch1;
  logic [VW-1:0] wts1, pix1;
  logic [15:0] bias1, res1;

  logic ww2, iv2, ir2, ov2, ordy2, sat2;
  logic [0:0] wch2;
  logic [VW-1:0] wts2, pix2;
  logic [15:0] bias2, res2;

  exp_t q1[$];
  exp_t q2[$];

  logic acc1_q = 1'b0;
  logic acc2_q = 1'b0;
  always @(posedge clk) begin
    acc1_q <= iv1 & ir1;
    acc2_q <= iv2 & ir2;
  end

  conv_datapath_pipelined #(.NUM_CHANNELS(1)) u_dut1 (
    .clk(clk), .reset(rst),
    .weight_write(ww1), .weight_ch(wch1),
    .weights(wts1), .bias(bias1),
    .in_valid(iv1), .in_ready(ir1),
    .pixel_data(pix1),
    .out_valid(ov1), .out_ready(ordy1),
    .add_result(res1), .result_sat(sat1)
  );

  conv_datapath_pipelined #(.NUM_CHANNELS(2)) u_dut2 (
    .clk(clk), .reset(rst),
    .weight_write(ww2), .weight_ch(wch2),
    .weights(wts2), .bias(bias2),
    .in_valid(iv2), .in_ready(ir2),
    .pixel_data(pix2),
    .out_valid(ov2), .out_ready(ordy2),
    .add_result(res2), .result_sat(sat2)
  );

  function automatic logic [VW-1:0] fill(
    input logic [15:0] v);
    logic [VW-1:0] r;
    for (int i = 0; i < KK; i++)
      r[i*DW +: DW] = v;
    return r;
  endfunction

  task automatic chk(input string nm,
    input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
        nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ov1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected1: got %0h expected none", res1);
      end else begin
        chk("res1", res1, q1[0].res);
        chk("sat1", sat1, q1[0].sat);
        if (!ordy1) chk("stall_in_ready1", ir1, 0);
        else begin
          if (q1[0].cyc >= 0)
            chk("latency1", cyc, q1[0].cyc);
          void'(q1.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected2: got %0h expected none", res2);
      end else begin
        chk("res2", res2, q2[0].res);
        chk("sat2", sat2, q2[0].sat);
        if (!ordy2) chk("stall_in_ready2", ir2, 0);
        else begin
          if (q2[0].cyc >= 0)
            chk("latency2", cyc, q2[0].cyc);
          void'(q2.pop_front());
        end
      end
    end
  end

  task automatic wr1(input logic [0:0] ch,
    input logic [VW-1:0] v);
    ww1 = 1'b1; wch1 = ch; wts1 = v;
    @(posedge clk); #1;
    ww1 = 1'b0;
  endtask

  task automatic wr2(input logic [0:0] ch,
    input logic [VW-1:0] v);
    ww2 = 1'b1; wch2 = ch; wts2 = v;
    @(posedge clk); #1;
    ww2 = 1'b0;
  endtask

  task automatic send1(input logic [VW-1:0] p,
    input logic [15:0] b, input bit push,
    input logic [15:0] r, input bit s, input bit lat);
    int n = 0;
    iv1 = 1'b1; pix1 = p; bias1 = b;
    do begin
      @(posedge clk); #1; n++;
    end while (!acc1_q && n < 50);
    iv1 = 1'b0;
    if (!acc1_q) begin
      checks++; errors++;
      $display("FAIL accept1: got timeout expected accept");
    end else if (push)
      q1.push_back('{r, s, lat ? cyc + 2 : -1});
  endtask

  task automatic send2(input logic [VW-1:0] p,
    input logic [15:0] b, input bit push,
    input logic [15:0] r, input bit s, input bit lat);
    int n = 0;
    iv2 = 1'b1; pix2 = p; bias2 = b;
    do begin
      @(posedge clk); #1; n++;
    end while (!acc2_q && n < 50);
    iv2 = 1'b0;
    if (!acc2_q) begin
      checks++; errors++;
      $display("FAIL accept2: got timeout expected accept");
    end else if (push)
      q2.push_back('{r, s, lat ? cyc + 2 : -1});
  endtask

  task automatic drain();
    int n = 0;
    while ((q1.size() + q2.size()) != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("drain", q1.size() + q2.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic reset_checks();
    @(negedge clk);
    chk("rst_ov1", ov1, 0);
    chk("rst_res1", res1, 0);
    chk("rst_sat1", sat1, 0);
    chk("rst_ir1", ir1, 1);
    chk("rst_ov2", ov2, 0);
    chk("rst_res2", res2, 0);
    chk("rst_sat2", sat2, 0);
    chk("rst_ir2", ir2, 1);
  endtask

  task automatic stall_ctl();
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ov1 && n < 50);
    if (!ov1) begin
      checks++; errors++;
      $display("FAIL stall_wait: got no out_valid expected out_valid");
    end
    repeat (5) @(posedge clk);
    #1 ordy1 = 1'b1;
  endtask

  initial begin
    logic [VW-1:0] v;
    logic [15:0] neg_exp;
    rst = 1'b1;
    ww1 = 0; wch1 = 0; wts1 = '0; bias1 = '0;
    iv1 = 0; pix1 = '0; ordy1 = 1'b1;
    ww2 = 0; wch2 = 0; wts2 = '0; bias2 = '0;
    iv2 = 0; pix2 = '0; ordy2 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    reset_checks();
    @(posedge clk); #1;

    // unity weights and pixels: 25 * 1.0
    wr1(0, fill(16'h0100));
    send1(fill(16'h0100), 16'h0, 1, 16'h1900, 0, 1);
    drain();

    // positive and negative saturation
`ifdef CONV_DATAPATH_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'h8000;
`endif
    wr1(0, fill(16'h7FFF));
    send1(fill(16'h7FFF), 16'h0, 1, 16'h7FFF, 1, 1);
    send1(fill(16'h8001), 16'h0, 1, neg_exp, 1, 1);
    drain();

    // round-half-up at +0.5 and -0.5 LSB
    v = '0;
    v[15:0] = 16'h0080;
    wr1(0, v);
    send1(fill(16'h0001), 16'h0, 1, 16'h0001, 0, 1);
    send1(fill(16'hFFFF), 16'h0, 1, 16'h0000, 0, 1);
    drain();

    // beat on the write edge uses old weights
    wr1(0, fill(16'h0100));
    fork
      wr1(0, fill(16'h0200));
      send1(fill(16'h0100), 16'h0, 1, 16'h1900, 0, 1);
    join
    send1(fill(16'h0100), 16'h0, 1, 16'h3200, 0, 1);
    drain();

    // back-to-back beats against a 5-cycle stall
    wr1(0, fill(16'h0100));
    ordy1 = 1'b0;
    fork
      begin
        send1(fill(16'h0010), 16'h0, 1, 16'h0190, 0, 0);
        send1(fill(16'h0020), 16'h0, 1, 16'h0320, 0, 0);
        send1(fill(16'h0030), 16'h0, 1, 16'h04B0, 0, 0);
        send1(fill(16'h0040), 16'h0, 1, 16'h0640, 0, 0);
      end
      stall_ctl();
    join
    drain();

    // two-channel accumulation with bias
    wr2(0, fill(16'h0100));
    wr2(1, fill(16'h0080));
    send2(fill(16'h0100), 16'h0, 0, 16'h0, 0, 0);
    send2(fill(16'h0200), 16'h0100, 1, 16'h3300, 0, 1);
    drain();

    // reset mid-accumulation discards the ch0 beat
    send2(fill(16'h0100), 16'h0, 0, 16'h0, 0, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    reset_checks();
    @(posedge clk); #1;
    wr2(0, fill(16'h0100));
    wr2(1, fill(16'h0080));
    send2(fill(16'h0100), 16'h0, 0, 16'h0, 0, 0);
    send2(fill(16'h0200), 16'h0100, 1, 16'h3300, 0, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
